// File: rtl/sweep_pkg.sv
// sweep_ctrl shared types and widths.
// Counter width, lap width, FSM states.
package sweep_pkg;

  localparam int CNT_W = 16;
  localparam int LAP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sweep_ctrl.sv
// Sweep sequencer driving an external up/down counter.
// Single-leg or triangle sweeps with abort, data_out fed back.
module sweep_ctrl
  import sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] start_val,
  input  logic [CNT_W-1:0] end_val,
  input  logic             bounce,
  input  logic [LAP_W-1:0] n_laps,
  input  logic [CNT_W-1:0] data_out,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic [CNT_W-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] start_reg;
  logic [CNT_W-1:0] end_reg;
  logic [CNT_W-1:0] tgt;
  logic             bounce_reg;
  logic [LAP_W-1:0] laps_reg;
  logic [LAP_W:0]   leg_cnt;
  logic [LAP_W:0]   last_leg;
  logic [LAP_W-1:0] laps_eff;
  logic             dir;
  logic             aborted_q;
  logic             match;
  logic             is_last;

  assign laps_eff = (laps_reg == '0) ? LAP_W'(1) : laps_reg;
  assign last_leg = bounce_reg ? ({laps_eff, 1'b0} - (LAP_W+1)'(1))
                               : '0;
  assign match    = (data_out == tgt);
  assign is_last  = (leg_cnt == last_leg);

  assign data_in  = start_reg;
  assign updn_cnt = dir;
  assign busy     = (state != IDLE);
  assign aborted  = aborted_q;

  // State register and sweep bookkeeping
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      start_reg  <= '0;
      end_reg    <= '0;
      tgt        <= '0;
      bounce_reg <= 1'b0;
      laps_reg   <= '0;
      leg_cnt    <= '0;
      dir        <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      aborted_q <= abort && (state != IDLE);
      if (state == IDLE && start && !abort) begin
        start_reg  <= start_val;
        end_reg    <= end_val;
        bounce_reg <= bounce;
        laps_reg   <= n_laps;
        leg_cnt    <= '0;
      end
      if (state == LOAD && !abort) begin
        dir     <= (end_reg >= start_reg);
        tgt     <= end_reg;
        leg_cnt <= '0;
      end
      if (state == RUN && !abort && match && !is_last) begin
        tgt     <= (tgt == end_reg) ? start_reg : end_reg;
        dir     <= ~dir;
        leg_cnt <= leg_cnt + 1'b1;
      end
    end
  end

  // Next-state and counter strobes
  always_comb begin
    state_nxt = state;
    ld_cnt    = 1'b1;
    count_enb = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = LOAD;
      end
      LOAD: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          ld_cnt    = 1'b0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          count_enb = !match;
          if (match && is_last) state_nxt = DONE;
        end
      end
      DONE: begin
        done      = !abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl.
// Includes a behavioural up/down counter closing the loop.
module tb_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_;
  logic        start;
  logic        abort;
  logic [15:0] start_val;
  logic [15:0] end_val;
  logic        bounce;
  logic [3:0]  n_laps;
  logic [15:0] data_out;
  logic        ld_cnt;
  logic        updn_cnt;
  logic        count_enb;
  logic [15:0] data_in;
  logic        busy;
  logic        done;
  logic        aborted;

  logic [15:0] cnt;
  logic [15:0] seq [0:127];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat;
  logic        enb_seen;

  always #5 clk = ~clk;

  assign data_out = cnt;

  // Model of the external up/down counter
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) cnt <= '0;
    else if (!ld_cnt) cnt <= data_in;
    else if (count_enb) cnt <= updn_cnt ? cnt + 16'd1 : cnt - 16'd1;
  end

  sweep_ctrl dut (
    .clk       (clk),
    .rst_      (rst_),
    .start     (start),
    .abort     (abort),
    .start_val (start_val),
    .end_val   (end_val),
    .bounce    (bounce),
    .n_laps    (n_laps),
    .data_out  (data_out),
    .ld_cnt    (ld_cnt),
    .updn_cnt  (updn_cnt),
    .count_enb (count_enb),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue a start, then follow the sweep until done or a cycle budget
  task automatic sweep(input logic [15:0] sv, input logic [15:0] ev,
                       input logic b, input logic [3:0] n);
    start_val = sv;
    end_val   = ev;
    bounce    = b;
    n_laps    = n;
    start     = 1'b1;
    cyc();
    start    = 1'b0;
    lat      = 0;
    enb_seen = 1'b0;
    while (!done && lat < 120) begin
      if (count_enb) enb_seen = 1'b1;
      seq[lat] = data_out;
      cyc();
      lat++;
    end
  endtask

  initial begin
    rst_      = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    start_val = '0;
    end_val   = '0;
    bounce    = 1'b0;
    n_laps    = '0;
    #12;
    chk("rst_ld", ld_cnt, 1);
    chk("rst_enb", count_enb, 0);
    chk("rst_updn", updn_cnt, 0);
    chk("rst_din", data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abt", aborted, 0);
    rst_ = 1'b1;
    cyc();

    // 5 -> 8 single leg, with an ignored start mid-run
    start_val = 16'd5;
    end_val   = 16'd8;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    chk("up_ld0", ld_cnt, 0);
    chk("up_busy", busy, 1);
    chk("up_din", data_in, 5);
    cyc();
    chk("up_d1", data_out, 5);
    chk("up_ld1", ld_cnt, 1);
    chk("up_dir", updn_cnt, 1);
    chk("up_enb1", count_enb, 1);
    start     = 1'b1;
    start_val = 16'd0;
    cyc();
    start = 1'b0;
    chk("up_d2", data_out, 6);
    chk("up_ign", ld_cnt, 1);
    cyc();
    chk("up_d3", data_out, 7);
    cyc();
    chk("up_d4", data_out, 8);
    chk("up_enb4", count_enb, 0);
    chk("up_nd4", done, 0);
    cyc();
    chk("up_done", done, 1);
    cyc();
    chk("up_done1", done, 0);
    chk("up_idle", busy, 0);
    chk("up_hold", data_out, 8);

    // 10 -> 7 down
    sweep(16'd10, 16'd7, 1'b0, 4'd0);
    chk("dn_lat", lat, 5);
    chk("dn_s1", seq[1], 10);
    chk("dn_s3", seq[3], 8);
    chk("dn_fin", data_out, 7);
    chk("dn_dir", updn_cnt, 0);
    cyc();

    // 0 -> 3 triangle, two laps
    sweep(16'd0, 16'd3, 1'b1, 4'd2);
    chk("tri_lat", lat, 17);
    chk("tri_s4", seq[4], 3);
    chk("tri_s5", seq[5], 3);
    chk("tri_s6", seq[6], 2);
    chk("tri_s8", seq[8], 0);
    chk("tri_s9", seq[9], 0);
    chk("tri_s13", seq[13], 3);
    chk("tri_s16", seq[16], 0);
    chk("tri_fin", data_out, 0);
    cyc();

    // Bounce with n_laps=0 acts as one lap: two legs
    sweep(16'd1, 16'd2, 1'b1, 4'd0);
    chk("lap0_lat", lat, 5);
    chk("lap0_fin", data_out, 1);
    cyc();

    // Equal start/end
    sweep(16'd100, 16'd100, 1'b0, 4'd0);
    chk("eq_lat", lat, 2);
    chk("eq_enb", enb_seen, 0);
    chk("eq_fin", data_out, 100);
    cyc();

    // Abort during RUN at 6
    start_val = 16'd5;
    end_val   = 16'd8;
    bounce    = 1'b0;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    chk("ab_d", data_out, 6);
    abort = 1'b1;
    #1;
    chk("ab_enb", count_enb, 0);
    chk("ab_ld", ld_cnt, 1);
    cyc();
    abort = 1'b0;
    chk("ab_pulse", aborted, 1);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    cyc();
    chk("ab_pulse1", aborted, 0);
    chk("ab_hold", data_out, 6);

    // Abort and start together in IDLE
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    chk("as_busy", busy, 0);
    chk("as_ld", ld_cnt, 1);
    chk("as_abt", aborted, 0);
    cyc();
    chk("as_abt1", aborted, 0);

    // Reset mid-RUN, then a clean 0 -> 2 sweep
    start_val = 16'd0;
    end_val   = 16'd10;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    #2;
    rst_ = 1'b0;
    #1;
    chk("mr_ld", ld_cnt, 1);
    chk("mr_enb", count_enb, 0);
    chk("mr_updn", updn_cnt, 0);
    chk("mr_din", data_in, 0);
    chk("mr_busy", busy, 0);
    cyc();
    chk("mr_done", done, 0);
    chk("mr_abt", aborted, 0);
    rst_ = 1'b1;
    cyc();
    chk("mr_abt1", aborted, 0);
    sweep(16'd0, 16'd2, 1'b0, 4'd0);
    chk("mr_lat", lat, 4);
    chk("mr_fin", data_out, 2);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
